// File: rtl/clk_div_n_if.sv
// Control/status bundle of the programmable clock divider.
// The master drives the divisor requests and the slave returns the divided clock and status.
interface clk_div_n_if #(
  parameter int CNT_W = 8
);
  logic             i_en;
  logic             i_load;
  logic [CNT_W-1:0] i_div;
  logic             o_clk_div;
  logic             o_tick;
  logic [CNT_W-1:0] o_div_cur;
  logic             o_div_err;

  modport master (
    output i_en, i_load, i_div,
    input  o_clk_div, o_tick, o_div_cur, o_div_err
  );

  modport slave (
    input  i_en, i_load, i_div,
    output o_clk_div, o_tick, o_div_cur, o_div_err
  );
endinterface

// File: rtl/clk_div_n.sv
// Programmable integer clock divider with an exact 50% duty cycle for even and odd divisors.
// Divisor changes are held in a shadow register and take effect only at a period boundary.
module clk_div_n #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 3
) (
  input  logic        clk,
  input  logic        reset,
  clk_div_n_if.slave  bus
);
  localparam logic [CNT_W-1:0] DEF_Q   = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] sh_q, sh_d;
  logic             pend_q, pend_d;
  logic             pos_q, pos_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic             neg_q;

  logic [CNT_W-1:0] ld_div, nd, hdiv, cnt_nxt;
  logic [CNT_W:0]   half;
  logic             wrap, apply;

  always_comb begin
    ld_div  = (bus.i_div < MIN_DIV) ? MIN_DIV : bus.i_div;
    wrap    = (cnt_q == cur_q - ONE);
    apply   = !bus.i_en || wrap;
    nd      = bus.i_load ? ld_div : (pend_q ? sh_q : cur_q);
    // The half point of a new period must come from the divisor it will run with.
    hdiv    = wrap ? nd : cur_q;
    half    = ({1'b0, hdiv} + (CNT_W+1)'(1)) >> 1;
    cnt_nxt = wrap ? '0 : cnt_q + ONE;

    sh_d    = bus.i_load ? ld_div : sh_q;
    err_d   = bus.i_load && (bus.i_div < MIN_DIV);

    if (apply) begin
      cur_d  = nd;
      pend_d = 1'b0;
    end else begin
      cur_d  = cur_q;
      pend_d = pend_q | bus.i_load;
    end

    if (bus.i_en) begin
      cnt_d  = cnt_nxt;
      pos_d  = ({1'b0, cnt_nxt} < half);
      tick_d = (cnt_nxt == '0);
    end else begin
      // Park one step before the wrap so the first enabled edge starts a period.
      cnt_d  = nd - ONE;
      pos_d  = 1'b0;
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= DEF_Q - ONE;
      cur_q  <= DEF_Q;
      sh_q   <= DEF_Q;
      pend_q <= 1'b0;
      pos_q  <= 1'b0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cur_q  <= cur_d;
      sh_q   <= sh_d;
      pend_q <= pend_d;
      pos_q  <= pos_d;
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end

  // Half-cycle delayed copy trims odd-divisor high time to exactly D/2 clocks.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) neg_q <= 1'b0;
    else        neg_q <= pos_q;
  end

  assign bus.o_clk_div = cur_q[0] ? (pos_q & neg_q) : pos_q;
  assign bus.o_tick    = tick_q;
  assign bus.o_div_cur = cur_q;
  assign bus.o_div_err = err_q;
endmodule

// File: tb/tb_clk_div_n.sv
// Randomised scoreboard bench for clk_div_n: a period-position model predicts every
// half-cycle of the divided clock plus tick, divisor and error status.
module tb_clk_div_n;
  logic clk = 1'b0;
  logic reset;

  clk_div_n_if #(.CNT_W(8)) bus ();

  clk_div_n #(.CNT_W(8), .DEF_DIV(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         at_pos;
    logic       clk_o;
    logic       tick;
    logic [7:0] cur;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b0;

  // Reference state: divisor in effect, pending shadow, and position inside the period.
  int m_d, m_sh, m_k;
  bit m_pend, m_run;

  function automatic bit hi(int d, int p);
    // p counts half clocks from the period start.
    if (d % 2 == 1) return (p >= 1) && (p < d + 1);
    else            return p < d;
  endfunction

  task automatic model_reset();
    m_d = 3; m_sh = 3; m_pend = 0; m_run = 0; m_k = 0;
  endtask

  task automatic step(bit en, bit ld, int dv);
    int   lv;
    bit   er;
    exp_t e;
    lv = (dv < 2) ? 2 : dv;
    er = ld && (dv < 2);
    if (!en || !m_run || m_k == m_d - 1) begin
      if (ld)          m_d = lv;
      else if (m_pend) m_d = m_sh;
      if (ld) m_sh = lv;
      m_pend = 0;
      m_run  = en;
      m_k    = 0;
    end else begin
      m_k = m_k + 1;
      if (ld) begin
        m_sh   = lv;
        m_pend = 1;
      end
    end
    bus.i_en   = en;
    bus.i_load = ld;
    bus.i_div  = 8'(dv);
    e.at_pos = 1'b1;
    e.clk_o  = m_run && hi(m_d, 2 * m_k);
    e.tick   = m_run && (m_k == 0);
    e.cur    = 8'(m_d);
    e.err    = er;
    q.push_back(e);
    e.at_pos = 1'b0;
    e.clk_o  = m_run && hi(m_d, 2 * m_k + 1);
    q.push_back(e);
    mon_on = 1'b1;
    @(negedge clk);
    #3;
  endtask

  task automatic check_direct(string name, logic [7:0] got, logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
    end
  endtask

  task automatic pop_check(bit at_pos);
    exp_t e;
    n_vec++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_underflow t=%0t", $time);
      return;
    end
    e = q.pop_front();
    if (e.at_pos != at_pos) begin
      n_fail++;
      $display("FAIL scoreboard_order t=%0t got_edge=%0d want_edge=%0d", $time, at_pos, e.at_pos);
    end else if (at_pos) begin
      if (bus.o_clk_div !== e.clk_o || bus.o_tick !== e.tick ||
          bus.o_div_cur !== e.cur || bus.o_div_err !== e.err) begin
        n_fail++;
        $display("FAIL posedge_outputs t=%0t got clk=%b tick=%b cur=%0d err=%b want clk=%b tick=%b cur=%0d err=%b",
                 $time, bus.o_clk_div, bus.o_tick, bus.o_div_cur, bus.o_div_err,
                 e.clk_o, e.tick, e.cur, e.err);
      end
    end else if (bus.o_clk_div !== e.clk_o) begin
      n_fail++;
      $display("FAIL negedge_clk_div t=%0t got=%b want=%b", $time, bus.o_clk_div, e.clk_o);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (mon_on) pop_check(1'b1);
      @(negedge clk); #1;
      if (mon_on) pop_check(1'b0);
    end
  end

  initial begin
    int guard;
    reset      = 1'b0;
    bus.i_en   = 1'b0;
    bus.i_load = 1'b0;
    bus.i_div  = 8'd0;
    model_reset();
    @(negedge clk); #3;
    check_direct("reset_clk_div", 8'(bus.o_clk_div), 8'd0);
    check_direct("reset_tick",    8'(bus.o_tick),    8'd0);
    check_direct("reset_div_cur", bus.o_div_cur,     8'd3);
    check_direct("reset_div_err", 8'(bus.o_div_err), 8'd0);
    @(negedge clk); #3;
    reset = 1'b1;

    // Default divide-by-3.
    repeat (10) step(1, 0, 0);
    // Load 4 while stopped, then enable.
    step(0, 0, 0);
    step(0, 1, 4);
    step(0, 0, 0);
    repeat (13) step(1, 0, 0);
    // Back to 3, then load 5 mid-period.
    step(1, 1, 3);
    repeat (7) step(1, 0, 0);
    guard = 0;
    while (m_k != 1 && guard < 10) begin step(1, 0, 0); guard++; end
    step(1, 1, 5);
    repeat (16) step(1, 0, 0);
    // Illegal divisors clamp to 2 and flag an error.
    step(1, 1, 1);
    repeat (6) step(1, 0, 0);
    step(1, 1, 0);
    repeat (5) step(1, 0, 0);
    step(0, 1, 0);
    repeat (3) step(1, 0, 0);
    // Drop enable mid-high at D=7, then restart.
    step(1, 1, 7);
    guard = 0;
    while (!(m_d == 7 && m_k == 2) && guard < 30) begin step(1, 0, 0); guard++; end
    repeat (2) step(0, 0, 0);
    repeat (16) step(1, 0, 0);
    // Reset mid-period at D=255.
    step(1, 1, 255);
    guard = 0;
    while (!(m_d == 255 && m_k == 60) && guard < 600) begin step(1, 0, 0); guard++; end
    mon_on = 1'b0;
    check_direct("pre_reset_high", 8'(bus.o_clk_div), 8'd1);
    reset = 1'b0;
    #1;
    check_direct("async_reset_clk_div", 8'(bus.o_clk_div), 8'd0);
    check_direct("async_reset_tick",    8'(bus.o_tick),    8'd0);
    check_direct("async_reset_div_cur", bus.o_div_cur,     8'd3);
    q.delete();
    repeat (2) begin @(negedge clk); #3; end
    reset = 1'b1;
    model_reset();
    repeat (12) step(1, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      bit en, ld;
      int dv;
      en = ($urandom_range(0, 19) != 0);
      ld = ($urandom_range(0, 11) == 0);
      dv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 10));
      step(en, ld, dv);
    end

    mon_on = 1'b0;
    check_direct("scoreboard_drained", 8'(q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
